// File: rtl/census_xor_scanner.sv
// census_xor_scanner
//
// Purpose: compares one reference census block against a stream of candidate
// blocks. Each candidate gets a {vertical, horizontal} position tag, and the
// block reports the XOR of reference and candidate plus its saturated popcount.
// Positions count the horizontal index down and the vertical index up. A scan
// ends after h_positions*v_positions candidates, followed by a fixed two-cycle
// drain.
//
// Optional feature: defining CENSUS_XOR_MASK_EN adds a per-bit mask. The mask
// is captured together with the reference and is applied to the XOR before the
// popcount. Timing is the same in both builds.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   ref_blk        reference census block
//   ref_blk_index  tag carried with the reference to blk_index_o
//   ref_valid      reference handshake in
//   ref_ready      reference handshake out (high only in IDLE)
//   ref_mask       bit mask captured with the reference (CENSUS_XOR_MASK_EN only)
//   cand_blk       candidate census block, in scan order
//   cand_valid     candidate handshake in
//   cand_ready     candidate handshake out (high only in SCAN)
//   xors           ref ^ cand (masked when the mask build is used)
//   sum            min(popcount(xors), 255)
//   out_coords     [15:8] vertical, [7:0] horizontal position of the result
//   blk_index_o    reference index of the scan that produced the result
//   sum_valid      one-cycle qualifier for xors/sum/out_coords/blk_index_o
//   busy           high whenever the scanner is not IDLE
module census_xor_scanner #(
    parameter int blk_size    = 256,
    parameter int h_positions = 48,
    parameter int v_positions = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [blk_size-1:0] ref_blk,
    input  logic [15:0]         ref_blk_index,
    input  logic                ref_valid,
    output logic                ref_ready,
`ifdef CENSUS_XOR_MASK_EN
    input  logic [blk_size-1:0] ref_mask,
`endif
    input  logic [blk_size-1:0] cand_blk,
    input  logic                cand_valid,
    output logic                cand_ready,
    output logic [blk_size-1:0] xors,
    output logic [7:0]          sum,
    output logic [15:0]         out_coords,
    output logic [15:0]         blk_index_o,
    output logic                sum_valid,
    output logic                busy
);

    localparam logic [7:0] H_LAST = 8'(h_positions - 1);
    localparam logic [7:0] V_LAST = 8'(v_positions - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              state_reg;
    logic                drain_cnt_reg;
    logic [7:0]          h_reg;
    logic [7:0]          v_reg;
    logic [blk_size-1:0] ref_reg;
    logic [15:0]         idx_reg;

    // Accept register: holds the candidate and its position tag so that the
    // XOR stage works from registered data.
    logic [blk_size-1:0] cand_reg;
    logic [15:0]         coords0_reg;
    logic                valid0_reg;

    // Stage 1: XOR, coordinates and index.
    logic [blk_size-1:0] xors1_reg;
    logic [15:0]         coords1_reg;
    logic [15:0]         idx1_reg;
    logic                valid1_reg;

    // Stage 2: output registers. They only load on a valid result, so the
    // outputs hold still between pulses.
    logic [blk_size-1:0] xors_reg;
    logic [7:0]          sum_reg;
    logic [15:0]         coords_reg;
    logic [15:0]         index_reg;
    logic                sum_valid_reg;

    logic [blk_size-1:0] diff_next;
    logic [31:0]         pop_cnt;
    logic [7:0]          sum_next;

`ifdef CENSUS_XOR_MASK_EN
    logic [blk_size-1:0] mask_reg;
`endif

    // Per-bit difference between the held reference and the accepted candidate.
    for (genvar gi = 0; gi < blk_size; gi++) begin : g_diff
`ifdef CENSUS_XOR_MASK_EN
        assign diff_next[gi] = (ref_reg[gi] ^ cand_reg[gi]) & mask_reg[gi];
`else
        assign diff_next[gi] = ref_reg[gi] ^ cand_reg[gi];
`endif
    end

    // Popcount over the stage-1 XOR. A full 256-bit mismatch cannot fit in
    // 8 bits, so the result saturates at 8'hFF.
    always_comb begin
        pop_cnt = 32'd0;
        for (int i = 0; i < blk_size; i++) begin
            pop_cnt = pop_cnt + 32'(xors1_reg[i]);
        end
        sum_next = (pop_cnt > 32'd255) ? 8'hFF : pop_cnt[7:0];
    end

    // Control FSM and position counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 1'b0;
            h_reg         <= H_LAST;
            v_reg         <= 8'd0;
            ref_reg       <= '0;
            idx_reg       <= 16'd0;
            cand_reg      <= '0;
            coords0_reg   <= 16'd0;
            valid0_reg    <= 1'b0;
`ifdef CENSUS_XOR_MASK_EN
            mask_reg      <= '0;
`endif
        end else begin
            valid0_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ref_valid) begin
                        ref_reg   <= ref_blk;
                        idx_reg   <= ref_blk_index;
`ifdef CENSUS_XOR_MASK_EN
                        mask_reg  <= ref_mask;
`endif
                        h_reg     <= H_LAST;
                        v_reg     <= 8'd0;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (cand_valid) begin
                        cand_reg    <= cand_blk;
                        coords0_reg <= {v_reg, h_reg};
                        valid0_reg  <= 1'b1;
                        if (h_reg == 8'd0) begin
                            h_reg <= H_LAST;
                            if (v_reg == V_LAST) begin
                                drain_cnt_reg <= 1'b0;
                                state_reg     <= DRAIN;
                            end else begin
                                v_reg <= v_reg + 8'd1;
                            end
                        end else begin
                            h_reg <= h_reg - 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles here let the last candidate clear both stages
                    // before a new reference can overwrite ref_reg.
                    if (drain_cnt_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        drain_cnt_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Datapath pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            xors1_reg     <= '0;
            coords1_reg   <= 16'd0;
            idx1_reg      <= 16'd0;
            valid1_reg    <= 1'b0;
            xors_reg      <= '0;
            sum_reg       <= 8'hFF;
            coords_reg    <= 16'hFFFF;
            index_reg     <= 16'd0;
            sum_valid_reg <= 1'b0;
        end else begin
            valid1_reg    <= valid0_reg;
            sum_valid_reg <= valid1_reg;
            if (valid0_reg) begin
                xors1_reg   <= diff_next;
                coords1_reg <= coords0_reg;
                idx1_reg    <= idx_reg;
            end
            if (valid1_reg) begin
                xors_reg   <= xors1_reg;
                sum_reg    <= sum_next;
                coords_reg <= coords1_reg;
                index_reg  <= idx1_reg;
            end
        end
    end

    assign ref_ready   = (state_reg == IDLE);
    assign cand_ready  = (state_reg == SCAN);
    assign busy        = (state_reg != IDLE);
    assign xors        = xors_reg;
    assign sum         = sum_reg;
    assign out_coords  = coords_reg;
    assign blk_index_o = index_reg;
    assign sum_valid   = sum_valid_reg;

endmodule

// File: tb/tb_census_xor_scanner.sv
// Testbench for census_xor_scanner with h_positions=4 and v_positions=2.
// The bench drives each accepted candidate into a scoreboard queue. Each queue
// entry records the expected result and the cycle in which its sum_valid pulse
// must appear. A monitor pops one entry per pulse and checks it. Between
// pulses the monitor checks that the outputs hold their values.
module tb_census_xor_scanner;

    localparam int B = 256;
    localparam int H = 4;
    localparam int V = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [B-1:0]  ref_blk = '0;
    logic [15:0]   ref_blk_index = 16'd0;
    logic          ref_valid = 1'b0;
    logic          ref_ready;
`ifdef CENSUS_XOR_MASK_EN
    logic [B-1:0]  ref_mask = '1;
`endif
    logic [B-1:0]  cand_blk = '0;
    logic          cand_valid = 1'b0;
    logic          cand_ready;
    logic [B-1:0]  xors;
    logic [7:0]    sum;
    logic [15:0]   out_coords;
    logic [15:0]   blk_index_o;
    logic          sum_valid;
    logic          busy;

    census_xor_scanner #(.blk_size(B), .h_positions(H), .v_positions(V)) dut (
        .clk(clk),
        .reset(reset),
        .ref_blk(ref_blk),
        .ref_blk_index(ref_blk_index),
        .ref_valid(ref_valid),
        .ref_ready(ref_ready),
`ifdef CENSUS_XOR_MASK_EN
        .ref_mask(ref_mask),
`endif
        .cand_blk(cand_blk),
        .cand_valid(cand_valid),
        .cand_ready(cand_ready),
        .xors(xors),
        .sum(sum),
        .out_coords(out_coords),
        .blk_index_o(blk_index_o),
        .sum_valid(sum_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [B-1:0] x;
        logic [7:0]   s;
        logic [15:0]  c;
        logic [15:0]  i;
        int           cyc;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic rst_at_edge = 1'b1;

    logic [B-1:0] ref_cur = '0;
    logic [B-1:0] mask_cur = '1;
    logic [15:0]  idx_cur = 16'd0;
    int           cand_k = 0;
    int           last_accept = 0;

    logic [B+39:0] prev_out = '0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // Monitor: one line per result pulse; stability check between pulses.
    always @(negedge clk) begin
        if (sum_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_pulse: coords=%h sum=%h at cycle %0d, required no pulse",
                         out_coords, sum, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (xors !== e.x || sum !== e.s || out_coords !== e.c ||
                    blk_index_o !== e.i || cyc !== e.cyc) begin
                    $display("FAIL result: got coords=%h sum=%h idx=%h cyc=%0d xors=%h, required coords=%h sum=%h idx=%h cyc=%0d xors=%h",
                             out_coords, sum, blk_index_o, cyc, xors, e.c, e.s, e.i, e.cyc, e.x);
                end else begin
                    passed++;
                    $display("result coords=%h sum=%h idx=%h cyc=%0d ok", out_coords, sum, blk_index_o, cyc);
                end
            end
        end else if (!rst_at_edge) begin
            checks++;
            if ({xors, sum, out_coords, blk_index_o} !== prev_out)
                $display("FAIL hold_stable: outputs changed without sum_valid at cycle %0d (coords=%h sum=%h)",
                         cyc, out_coords, sum);
            else
                passed++;
        end
        prev_out <= {xors, sum, out_coords, blk_index_o};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [B-1:0] rand_blk();
        logic [B-1:0] r;
        for (int w = 0; w < B / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_ref(input logic [B-1:0] blk, input logic [15:0] idx,
                            input logic [B-1:0] mask, input bit keep);
        int n = 0;
        ref_blk = blk;
        ref_blk_index = idx;
`ifdef CENSUS_XOR_MASK_EN
        ref_mask = mask;
`endif
        ref_valid = 1'b1;
        while (ref_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ref_ready !== 1'b1) begin
            checks++;
            $display("FAIL ref_wait: ref_ready=%b, required 1 within 100 cycles", ref_ready);
        end
        ref_cur  = blk;
        idx_cur  = idx;
`ifdef CENSUS_XOR_MASK_EN
        mask_cur = mask;
`else
        mask_cur = mask | '1;
`endif
        cand_k   = 0;
        @(negedge clk);
        if (!keep) ref_valid = 1'b0;
        $display("ref idx=%h accepted at cycle %0d", idx, cyc);
    endtask

    task automatic send_cand(input logic [B-1:0] c, input int gap);
        int n = 0;
        exp_t e;
        int cnt;
        cand_blk = c;
        cand_valid = 1'b1;
        while (cand_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cand_ready !== 1'b1) begin
            checks++;
            $display("FAIL cand_wait: cand_ready=%b, required 1 within 100 cycles", cand_ready);
        end
        e.x   = (ref_cur ^ c) & mask_cur;
        cnt   = $countones(e.x);
        e.s   = (cnt > 255) ? 8'hFF : 8'(cnt);
        e.c   = {8'(cand_k / H), 8'(H - 1 - (cand_k % H))};
        e.i   = idx_cur;
        e.cyc = cyc + 3;
        q.push_back(e);
        cand_k++;
        last_accept = cyc + 1;
        @(negedge clk);
        cand_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((q.size() != 0 || busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || busy !== 1'b0)
            $display("FAIL %s_drain: pending=%0d busy=%b, required 0 and 0", name, q.size(), busy);
        else
            passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 8;
        if (sum_valid !== 1'b0) $display("FAIL reset_sum_valid: got %b, required 0", sum_valid); else passed++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
        if (sum !== 8'hFF) $display("FAIL reset_sum: got %h, required ff", sum); else passed++;
        if (xors !== '0) $display("FAIL reset_xors: got %h, required 0", xors); else passed++;
        if (out_coords !== 16'hFFFF) $display("FAIL reset_coords: got %h, required ffff", out_coords); else passed++;
        if (blk_index_o !== 16'h0) $display("FAIL reset_index: got %h, required 0000", blk_index_o); else passed++;
        if (ref_ready !== 1'b1) $display("FAIL reset_ref_ready: got %b, required 1", ref_ready); else passed++;
        if (cand_ready !== 1'b0) $display("FAIL reset_cand_ready: got %b, required 0", cand_ready); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        send_ref('0, 16'h0011, '1, 1'b0);
        for (int k = 0; k < H * V; k++) send_cand(rand_blk(), 0);
        wait_empty("back_to_back");
    endtask

    task automatic test_saturation();
        logic [B-1:0] ones;
        logic [B-1:0] one_bit;
        logic [B-1:0] two_bits;
        ones     = '1;
        one_bit  = '0;
        one_bit[17] = 1'b1;
        two_bits = '0;
        two_bits[0] = 1'b1;
        two_bits[B-1] = 1'b1;
        send_ref(ones, 16'h0022, '1, 1'b0);
        send_cand('0, 0);          // 256 differing bits -> saturates to ff
        send_cand(ones, 0);        // identical -> 0
        send_cand(one_bit, 0);     // 255 differing bits
        send_cand(two_bits, 0);    // 254 differing bits
        for (int k = 4; k < H * V; k++) send_cand(rand_blk(), 0);
        wait_empty("saturation");
    endtask

    task automatic test_gaps();
        send_ref(rand_blk(), 16'h0033, '1, 1'b0);
        for (int k = 0; k < H * V; k++) send_cand(rand_blk(), 1);
        wait_empty("gaps");
        // Busy check after a final accept with no trailing gap.
        send_ref(rand_blk(), 16'h0034, '1, 1'b0);
        for (int k = 0; k < H * V; k++) send_cand(rand_blk(), (k % 2 == 0) ? 1 : 0);
        checks += 4;
        if (busy !== 1'b1) $display("FAIL busy_accept0: got %b, required 1", busy); else passed++;
        @(negedge clk);
        if (busy !== 1'b1) $display("FAIL busy_accept1: got %b, required 1", busy); else passed++;
        @(negedge clk);
        if (busy !== 1'b0) $display("FAIL busy_accept2: got %b, required 0", busy); else passed++;
        if (ref_ready !== 1'b1) $display("FAIL ready_after_drain: got %b, required 1", ref_ready); else passed++;
        wait_empty("gaps_busy");
    endtask

    task automatic test_ref_hold();
        logic [B-1:0] r2;
        int n = 0;
        r2 = rand_blk();
        send_ref(rand_blk(), 16'h0123, '1, 1'b1);
        // ref_valid stays high with new contents; it must be ignored mid-scan.
        ref_blk = r2;
        ref_blk_index = 16'h0456;
        for (int k = 0; k < H * V; k++) send_cand(rand_blk(), 0);
        while (ref_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ref_ready !== 1'b1 || cyc !== last_accept + 2)
            $display("FAIL ref_hold_accept: ready=%b at cycle %0d, required 1 at cycle %0d",
                     ref_ready, cyc, last_accept + 2);
        else
            passed++;
        ref_cur = r2;
        idx_cur = 16'h0456;
        mask_cur = '1;
        cand_k  = 0;
        @(negedge clk);
        ref_valid = 1'b0;
        for (int k = 0; k < H * V; k++) send_cand(rand_blk(), 0);
        wait_empty("ref_hold");
    endtask

    task automatic test_reset_mid();
        exp_t keep_q[$];
        int pulses = 0;
        send_ref(rand_blk(), 16'h0077, '1, 1'b0);
        for (int k = 0; k < 3; k++) send_cand(rand_blk(), 0);
        reset = 1'b1;
        // Results due at or after the reset edge are discarded.
        foreach (q[j]) if (q[j].cyc < cyc + 1) keep_q.push_back(q[j]);
        q = keep_q;
        @(negedge clk);
        reset = 1'b0;
        checks += 2;
        if (ref_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b, required 1", ref_ready); else passed++;
        if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b, required 0", busy); else passed++;
        @(negedge clk);
        repeat (6) begin
            if (sum_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0 || q.size() != 0)
            $display("FAIL reset_mid_flush: pulses=%0d pending=%0d, required 0 and 0", pulses, q.size());
        else
            passed++;
        // The scanner must be fully usable afterwards, starting at {0, H-1}.
        send_ref(rand_blk(), 16'h0078, '1, 1'b0);
        for (int k = 0; k < H * V; k++) send_cand(rand_blk(), 0);
        wait_empty("reset_mid_rescan");
    endtask

`ifdef CENSUS_XOR_MASK_EN
    task automatic test_mask();
        logic [B-1:0] m;
        m = '0;
        m[7:0] = 8'h0F;
        send_ref('1, 16'h0099, m, 1'b0);
        for (int k = 0; k < H * V; k++) send_cand('0, 0);
        wait_empty("mask");
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_saturation();
        test_gaps();
        test_ref_hold();
        test_reset_mid();
`ifdef CENSUS_XOR_MASK_EN
        test_mask();
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/census_xor_scanner.md
CENSUS_XOR_SCANNER -- requirements
Module: census_xor_scanner

Interface
REQ-001 SHALL have parameter blk_size, default 256, census block width in bits.
REQ-002 SHALL have parameter h_positions, default 48, horizontal candidates per row, range 1..256.
REQ-003 SHALL have parameter v_positions, default 1, vertical candidate rows, range 1..256.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ref_blk  input  blk_size  reference census block.
REQ-007 SHALL have port ref_blk_index  input  16  block index tag for the reference.
REQ-008 SHALL have port ref_valid / ref_ready  input / output  1 / 1  reference handshake.
REQ-009 SHALL have port cand_blk  input  blk_size  candidate census block, in scan order.
REQ-010 SHALL have port cand_valid / cand_ready  input / output  1 / 1  candidate handshake.
REQ-011 SHALL have port xors  output  blk_size  ref XOR candidate.
REQ-012 SHALL have port sum  output  8  popcount of xors, saturated.
REQ-013 SHALL have port out_coords  output  16  [15:8] vertical, [7:0] horizontal candidate position.
REQ-014 SHALL have port blk_index_o  output  16  ref_blk_index of the current scan.
REQ-015 SHALL have port sum_valid  output  1  one-cycle qualifier for xors/sum/out_coords/blk_index_o.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN; ref_ready=1 only in IDLE; cand_ready=1 only in SCAN.
REQ-018 SHALL, on ref_valid&&ref_ready, capture ref_blk and ref_blk_index, load v=0, h=h_positions-1, enter SCAN.
REQ-019 SHALL, per cand_valid&&cand_ready, tag the candidate with {v,h}, then decrement h; at h=0 reload h=h_positions-1 and increment v.
REQ-020 SHALL, on accepting candidate {v_positions-1, 0}, enter DRAIN; last emitted out_coords of every scan is {v_positions-1, 8'h00}.
REQ-021 SHALL stay in DRAIN exactly 2 cycles, then enter IDLE; a new reference is accepted no earlier than the next cycle.
REQ-022 SHALL be 2-stage pipelined: stage 1 registers xors, coords, index; stage 2 registers sum; a candidate accepted at edge N gives sum_valid=1 for the cycle after edge N+2.
REQ-023 SHALL sustain one candidate per cycle; cand_valid gaps produce matching sum_valid gaps, no reordering.
REQ-024 SHALL compute sum = min(popcount(xors), 255); popcount of 256 yields 8'hFF.
REQ-025 SHALL assert sum_valid exactly h_positions*v_positions times per reference, each for one cycle; downstream has no backpressure.
REQ-026 SHALL hold xors, sum, out_coords, blk_index_o stable while sum_valid=0.
REQ-027 SHALL ignore ref_valid outside IDLE and cand_valid outside SCAN.

Reset
REQ-028 SHALL, on reset, enter IDLE, clear both pipeline stage valids, and drive sum_valid=0, busy=0, sum=8'hFF, xors=0, out_coords=16'hFFFF, blk_index_o=0.
REQ-029 SHALL, on reset mid-SCAN or mid-DRAIN, discard in-flight candidates with no further sum_valid pulses for that scan.

Configuration
REQ-030 SHALL, with CENSUS_XOR_MASK_EN defined, add input ref_mask [blk_size-1:0], captured with ref_blk, and output xors=(ref^cand)&mask with sum counted on masked xors.
REQ-031 SHALL, without CENSUS_XOR_MASK_EN, omit ref_mask and output unmasked xors; all timing identical in both builds.

Verification
REQ-032 SHALL cover: h_positions=4, v_positions=2, ref all-zero, 8 back-to-back candidates -> 8 sum_valid pulses, coords 0x0003,0x0002,0x0001,0x0000,0x0103,...,0x0100, first pulse 2 cycles after first accept.
REQ-033 SHALL cover: ref all-ones, candidate all-zeros (blk_size=256) -> sum=8'hFF, xors all-ones.
REQ-034 SHALL cover: cand_valid toggled 1,0,1,0 -> sum_valid pulses spaced identically, busy high until 2 cycles after last accept.
REQ-035 SHALL cover: ref_valid held high during SCAN with ref_blk_index=0x0123 then 0x0456 -> second ref accepted only after DRAIN, blk_index_o switches 0x0123 to 0x0456 at scan boundary.
REQ-036 SHALL cover: reset asserted 1 cycle after 3rd candidate accept -> no further sum_valid, ref_ready=1 the cycle after reset deasserts.
REQ-037 SHALL cover (CENSUS_XOR_MASK_EN): mask=0x0F in low byte only, ref^cand=all-ones -> sum=4.
